// File: rtl/bist_march_sequencer.sv
// March C- BIST sequencer: issues one registered read or write per clock
// while it owns the memory (NbarT=1), then raises a sticky done flag.
module bist_march_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  NbarT,
    output logic [ADDR_WIDTH-1:0] bist_addr,
    output logic [DATA_WIDTH-1:0] bist_data,
    output logic                  bist_we,
    output logic                  bist_re,
    output logic [DATA_WIDTH-1:0] exp_data,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [2:0]            ELEM_LAST = 3'd5;

    state_t                  state_q, state_d;
    logic [2:0]              elem_q, elem_d;
    logic                    op_q, op_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    start_q, abort_q;

    logic                    nbart_q, nbart_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    we_q, we_d;
    logic                    re_q, re_d;
    logic [ADDR_WIDTH-1:0]   out_addr_q, out_addr_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [DATA_WIDTH-1:0]   exp_q, exp_d;

    logic                    elem_down;
    logic                    next_elem_down;
    logic                    two_op;
    logic                    last_op_at_addr;
    logic                    at_terminal;
    logic                    is_read_d;
    logic                    value_d;

    // Capture start/abort so the FSM reacts one edge after they are sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            start_q <= start;
            abort_q <= abort;
        end
    end

    // Element/op/address walk and the IDLE/RUN/DONE transitions.
    always_comb begin
        state_d         = state_q;
        elem_d          = elem_q;
        op_d            = op_q;
        addr_d          = addr_q;
        elem_down       = (elem_q == 3'd3) || (elem_q == 3'd4);
        next_elem_down  = (elem_q == 3'd2) || (elem_q == 3'd3);
        two_op          = (elem_q >= 3'd1) && (elem_q <= 3'd4);
        last_op_at_addr = !two_op || op_q;
        at_terminal     = elem_down ? (addr_q == '0) : (addr_q == ADDR_LAST);

        case (state_q)
            IDLE, DONE: begin
                if (start_q) begin
                    state_d = RUN;
                    elem_d  = 3'd0;
                    op_d    = 1'b0;
                    addr_d  = '0;
                end
            end
            RUN: begin
                if (!last_op_at_addr) begin
                    op_d = 1'b1;
                end else begin
                    op_d = 1'b0;
                    if (at_terminal) begin
                        if (elem_q == ELEM_LAST) begin
                            state_d = DONE;
                            elem_d  = 3'd0;
                            addr_d  = '0;
                        end else begin
                            elem_d = elem_q + 3'd1;
                            addr_d = next_elem_down ? ADDR_LAST : '0;
                        end
                    end else begin
                        addr_d = elem_down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort_q) begin
            state_d = IDLE;
            elem_d  = 3'd0;
            op_d    = 1'b0;
            addr_d  = '0;
        end
    end

    // Decode the upcoming op into the registered output values.
    always_comb begin
        nbart_d    = 1'b0;
        busy_d     = 1'b0;
        done_d     = (state_d == DONE);
        we_d       = 1'b0;
        re_d       = 1'b0;
        out_addr_d = '0;
        out_data_d = '0;
        exp_d      = '0;
        is_read_d  = (elem_d == 3'd5) || ((elem_d >= 3'd1) && (elem_d <= 3'd4) && !op_d);
        case (elem_d)
            3'd1, 3'd3: value_d = op_d;
            3'd2, 3'd4: value_d = !op_d;
            default:    value_d = 1'b0;
        endcase

        if (state_d == RUN) begin
            nbart_d    = 1'b1;
            busy_d     = 1'b1;
            we_d       = !is_read_d;
            re_d       = is_read_d;
            out_addr_d = addr_d;
            out_data_d = {DATA_WIDTH{value_d}};
            if (is_read_d) begin
                exp_d = {DATA_WIDTH{value_d}};
            end
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            elem_q     <= 3'd0;
            op_q       <= 1'b0;
            addr_q     <= '0;
            nbart_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
            exp_q      <= '0;
        end else begin
            state_q    <= state_d;
            elem_q     <= elem_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            nbart_q    <= nbart_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            we_q       <= we_d;
            re_q       <= re_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            exp_q      <= exp_d;
        end
    end

    assign NbarT     = nbart_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign bist_we   = we_q;
    assign bist_re   = re_q;
    assign bist_addr = out_addr_q;
    assign bist_data = out_data_q;
    assign exp_data  = exp_q;

endmodule

// File: tb/tb_bist_march_sequencer.sv
// Directed bench for the March C- sequencer at ADDR_WIDTH=3 (N=8, 80 ops).
module tb_bist_march_sequencer;

    localparam int N       = 8;
    localparam int NOPS    = 10 * N;
    localparam int RECLEN  = 91;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       NbarT;
    logic [2:0] bist_addr;
    logic [7:0] bist_data;
    logic       bist_we;
    logic       bist_re;
    logic [7:0] exp_data;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cycle;
        logic       we;
        logic       re;
        logic [2:0] addr;
        logic [7:0] val;
    } vec_t;

    vec_t vecs[5];

    logic       rec_nbart [RECLEN];
    logic       rec_done  [RECLEN];
    logic       rec_we    [RECLEN];
    logic       rec_re    [RECLEN];
    logic [2:0] rec_addr  [RECLEN];
    logic [7:0] rec_data  [RECLEN];
    logic [7:0] rec_exp   [RECLEN];

    logic       gold_we   [RECLEN];
    logic       gold_re   [RECLEN];
    logic [2:0] gold_addr [RECLEN];
    logic [7:0] gold_val  [RECLEN];

    bist_march_sequencer #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .NbarT     (NbarT),
        .bist_addr (bist_addr),
        .bist_data (bist_data),
        .bist_we   (bist_we),
        .bist_re   (bist_re),
        .exp_data  (exp_data),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic a);
        start = s;
        abort = a;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_out();
        return {8'h00, NbarT, busy, done, bist_we, bist_re, bist_addr, bist_data, exp_data};
    endfunction

    // Golden March C- op stream built from an element table.
    task automatic build_golden();
        int  c;
        int  nops  [6] = '{1, 2, 2, 2, 2, 1};
        bit  down  [6] = '{0, 0, 0, 1, 1, 0};
        bit  rd    [6][2] = '{'{0, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}};
        bit  val   [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};
        c = 1;
        for (int e = 0; e < 6; e++) begin
            for (int ai = 0; ai < N; ai++) begin
                for (int o = 0; o < nops[e]; o++) begin
                    gold_we[c]   = !rd[e][o];
                    gold_re[c]   = rd[e][o];
                    gold_addr[c] = down[e] ? 3'(N - 1 - ai) : 3'(ai);
                    gold_val[c]  = val[e][o] ? 8'hFF : 8'h00;
                    c++;
                end
            end
        end
    endtask

    task automatic launch();
        applyStimulus(1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic record(input int c);
        rec_nbart[c] = NbarT;
        rec_done[c]  = done;
        rec_we[c]    = bist_we;
        rec_re[c]    = bist_re;
        rec_addr[c]  = bist_addr;
        rec_data[c]  = bist_data;
        rec_exp[c]   = exp_data;
    endtask

    // Launch a run and record 90 op-cycles; optionally pulse start at cycle start_at.
    task automatic do_run(input int start_at);
        launch();
        record(0);
        for (int c = 1; c < RECLEN; c++) begin
            step();
            record(c);
            if (c == start_at) applyStimulus(1'b1, 1'b0);
            else if (c == start_at + 1) applyStimulus(1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0);
    endtask

    // Replay recorded ops into an 8-word memory; return first read mismatch cycle.
    function automatic int replay(input bit stuck);
        logic [7:0] mem [N];
        logic [7:0] d;
        for (int i = 0; i < N; i++) mem[i] = 8'h5A;
        for (int c = 1; c <= NOPS; c++) begin
            if (rec_we[c]) begin
                d = rec_data[c];
                if (stuck && rec_addr[c] == 3'd5) d[0] = 1'b0;
                mem[rec_addr[c]] = d;
            end
            if (rec_re[c] && mem[rec_addr[c]] !== rec_exp[c]) return c;
        end
        return 0;
    endfunction

    task automatic check_run(input string tag, input bit full);
        int cnt;
        cnt = 0;
        for (int c = 1; c < RECLEN; c++) cnt += int'(rec_nbart[c]);
        checkOutput({tag, "_opcount"}, 32'(cnt), 32'(NOPS));
        checkOutput({tag, "_pre_nbart"}, {31'd0, rec_nbart[0]}, 32'd0);
        checkOutput({tag, "_end_done"}, {30'd0, rec_done[NOPS + 1], rec_nbart[NOPS + 1]}, 32'h2);
        checkOutput({tag, "_last_done"}, {31'd0, rec_done[NOPS]}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("%s_vec_c%0d", tag, vecs[i].cycle),
                {19'd0, rec_we[vecs[i].cycle], rec_re[vecs[i].cycle], rec_addr[vecs[i].cycle],
                 rec_re[vecs[i].cycle] ? rec_exp[vecs[i].cycle] : rec_data[vecs[i].cycle]},
                {19'd0, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].val});
        end
        if (full) begin
            for (int c = 1; c <= NOPS; c++) begin
                checkOutput($sformatf("%s_op%0d", tag, c),
                    {11'd0, rec_we[c], rec_re[c], rec_addr[c], rec_data[c], rec_re[c] ? rec_exp[c] : 8'h00},
                    {11'd0, gold_we[c], gold_re[c], gold_addr[c], gold_val[c], gold_re[c] ? gold_val[c] : 8'h00});
            end
            checkOutput({tag, "_mem_clean"}, 32'(replay(1'b0)), 32'd0);
            checkOutput({tag, "_mem_stuck"}, 32'(replay(1'b1)), 32'd35);
        end
    endtask

    initial begin
        vecs[0] = '{cycle: 1,  we: 1'b1, re: 1'b0, addr: 3'd0, val: 8'h00};
        vecs[1] = '{cycle: 9,  we: 1'b0, re: 1'b1, addr: 3'd0, val: 8'h00};
        vecs[2] = '{cycle: 10, we: 1'b1, re: 1'b0, addr: 3'd0, val: 8'hFF};
        vecs[3] = '{cycle: 41, we: 1'b0, re: 1'b1, addr: 3'd7, val: 8'h00};
        vecs[4] = '{cycle: 80, we: 1'b0, re: 1'b1, addr: 3'd7, val: 8'h00};
        build_golden();

        // Reset held with start high, then idle for 10 cycles.
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs", all_out(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput($sformatf("idle_c%0d", i), all_out(), 32'd0);
        end

        // Full run with per-op golden comparison and memory scoreboard.
        do_run(0);
        check_run("run1", 1'b1);

        // Abort during op cycle 30.
        launch();
        for (int c = 1; c <= 30; c++) step();
        checkOutput("abort_pre_nbart", {31'd0, NbarT}, 32'd1);
        applyStimulus(1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0);
        step();
        checkOutput("abort_outputs", all_out(), 32'd0);
        step();
        checkOutput("abort_stays_idle", all_out(), 32'd0);

        // Simultaneous start and abort in IDLE.
        applyStimulus(1'b1, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("start_abort_idle_c%0d", i), all_out(), 32'd0);
        end

        // Restart from DONE one cycle after done rises.
        launch();
        for (int c = 1; c <= NOPS + 1; c++) step();
        checkOutput("restart_done_seen", {31'd0, done}, 32'd1);
        applyStimulus(1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0);
        checkOutput("restart_done_held", {31'd0, done}, 32'd1);
        step();
        checkOutput("restart_first_op",
            {16'd0, done, NbarT, bist_we, bist_re, 1'b0, bist_addr, bist_data},
            {16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00});
        for (int c = 2; c <= NOPS + 1; c++) step();
        checkOutput("restart_end_done", {30'd0, done, NbarT}, 32'h2);

        // Start pulsed mid-run is ignored.
        do_run(20);
        check_run("ignstart", 1'b0);

        // Asynchronous reset during op cycle 45.
        launch();
        for (int c = 1; c <= 45; c++) step();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs", all_out(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        checkOutput("post_reset_idle", all_out(), 32'd0);
        do_run(0);
        check_run("run2", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Strobes must never overlap.
    always @(negedge clk) begin
        if (rst_n && bist_we && bist_re) begin
            checks++;
            errors++;
            $display("[TB] FAIL strobe_overlap actual=we1_re1 required=exclusive");
        end
    end

endmodule

// File: doc/bist_march_sequencer.md
# bist_march_sequencer

Generates the March C- operation stream that drives the BIST side of the memory address/data multiplexer. After a `start` pulse it takes ownership of the memory by raising `NbarT`, then issues one read or write per clock. Each operation is registered as an address, data word, write strobe and read strobe. For every read it also presents the expected data word, which the downstream response comparator uses. When the algorithm completes it releases `NbarT` and flags `done`.

## Interface
- `ADDR_WIDTH`, 8, memory address width; N = 2^ADDR_WIDTH words
- `DATA_WIDTH`, 8, memory data width
- `clk` input 1 — single clock; all logic is rising-edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `start` input 1 — begins a test when sampled high in IDLE.
- `abort` input 1 — ends the test immediately from any state.
- `NbarT` output 1 — 1 while in RUN only; selects the BIST path in the multiplexer.
- `bist_addr` output ADDR_WIDTH — operation address.
- `bist_data` output DATA_WIDTH — write data: all-0 or all-1 background.
- `bist_we` output 1 — write strobe, one cycle per write.
- `bist_re` output 1 — read strobe, one cycle per read.
- `exp_data` output DATA_WIDTH — expected read value; meaningful only when `bist_re`=1.
- `busy` output 1 — 1 in RUN.
- `done` output 1 — sticky completion flag.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN when `start`=1.
- RUN → DONE after the last operation of M5.
- DONE → RUN when `start`=1; this clears `done`.
- Any state → IDLE when `abort`=1. `abort` has priority over `start` and over completion.
- RUN walks a 3-bit element index (e), a 1-bit op index (o) and the address counter. Elements:
  - M0 ⇑(w0)
  - M1 ⇑(r0,w1)
  - M2 ⇑(r1,w0)
  - M3 ⇓(r0,w1)
  - M4 ⇓(r1,w0)
  - M5 ⇑(r0)
- ⇑ counts addresses 0→N-1; ⇓ counts N-1→0. Each element starts at its first address.
- Two-op elements perform both ops at one address before the address steps.
- Total operations = 10N. For ADDR_WIDTH=8 that is 2560.
- Data encoding: "0" = all zeros, "1" = all ones, replicated across DATA_WIDTH. On a read, `bist_data` holds the same value as `exp_data`.
- The address counter wraps naturally at its width. Element advance is decided by comparing against the terminal address (N-1 for ⇑, 0 for ⇓), never by overflow.
- `start` is ignored in RUN. `abort` in IDLE is a no-op.
- Reset state: IDLE. All outputs are 0 at reset: `NbarT`, `bist_addr`, `bist_data`, `bist_we`, `bist_re`, `exp_data`, `busy`, `done`.
- In IDLE and DONE, `bist_we`, `bist_re` and `NbarT` are 0. `bist_addr`, `bist_data` and `exp_data` are driven to 0.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `start` sampled at edge k gives the following at edge k+1:
  - `NbarT`=`busy`=1
  - first op M0 w0 at address 0: `bist_we`=1, `bist_data`=0
- One operation per cycle, back-to-back, with no idle cycles between elements.
- The final op (M5 r0 at address N-1) is present after edge k+10N.
- At edge k+10N+1: `NbarT`=`busy`=0, strobes=0, `done`=1.
- `abort` sampled at edge j: at edge j+1 all outputs are at their reset values, including `done`=0. No partial op is emitted after edge j+1.
- `rst_n` asserted mid-RUN forces reset values immediately, asynchronously. The sequencer resumes in IDLE on the first edge after deassertion.
- `bist_we` and `bist_re` are never both 1 in the same cycle.

## Test plan
- Reset, then idle: hold `rst_n`=0 with `start`=1, then release `rst_n` with `start`=0 for 10 cycles → all outputs stay 0 and `NbarT`=0.
- Full run with ADDR_WIDTH=3 (N=8): pulse `start` → exactly 80 consecutive op cycles with `NbarT`=1, then `done`=1 and `NbarT`=0 on the next cycle. Check per-cycle ops:
  - cycle 1: w, addr 0, data 00
  - cycle 9: r, addr 0, exp 00
  - cycle 10: w, addr 0, data FF
  - cycle 41: r, addr 7, exp 00 (M3 start)
  - cycle 80: r, addr 7, exp 00
- Scoreboard: an 8-word memory model driven through the multiplexer with NbarT=1 → every read returns `exp_data`. With a stuck-at-0 bit injected at address 5, a mismatch occurs first at the M2 r1 of address 5.
- Abort mid-RUN at op cycle 30 → one cycle later `NbarT`=`busy`=`done`=0 and the strobes are 0. Simultaneous `start`+`abort` in IDLE → remains IDLE.
- Restart from DONE: `start` one cycle after `done` → `done` clears, and the first op is w0 at address 0 on the next cycle. `start` pulsed at op cycle 20 of a run → ignored, and the total run length stays 80.
- Async reset at op cycle 45 → outputs go to 0 before the next clock edge. After release, `start` → a full clean 80-op run.
